aes_mcol_seq: RTL and testbench

Sequential, parametrised MixColumns engine for the AES datapath, supporting both forward (encrypt) and inverse (decrypt) MixColumns. It accepts a full state over a valid/ready handshake and processes COLS columns per cycle using an iterative column counter. It presents the result over a second valid/ready handshake. It sits between ShiftRows and AddRoundKey in the round pipeline. GF(2^8) arithmetic uses xtime shift/reduce logic, so no EXP/LN lookup tables are needed.

---
 rtl/aes_const_pkg.sv | 34 +++
 rtl/aes_mcol_seq_col.sv | 41 ++++
 rtl/aes_mcol_seq.sv | 110 +++++++++++
 tb/tb_aes_mcol_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_const_pkg.sv
// Shared AES constants and GF(2^8) helpers for the MixColumns engine.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package aes_const;

   // Columns per AES state
   localparam int NB = 4;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mcol_fsm_t;

   // First row of each circulant matrix, nibble k = coefficient in column k.
   // Forward row 0: 02 03 01 01.  Inverse row 0: 0e 0b 0d 09.
   localparam logic [15:0] FWD_COEF = 16'h1132;
   localparam logic [15:0] INV_COEF = 16'h9dbe;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Coefficient at circulant offset k; every matrix row is row 0 rotated.
   function automatic logic [3:0] mcol_coef(input logic inv, input logic [1:0] k);
      return inv ? INV_COEF[{k, 2'b00} +: 4] : FWD_COEF[{k, 2'b00} +: 4];
   endfunction

   // Multiply by a 4-bit constant: XOR of b, 2b, 4b, 8b chosen by c's bits.
   function automatic logic [7:0] gf_mul_c(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] x1, x2, x3;
      x1 = xtime(b);
      x2 = xtime(x1);
      x3 = xtime(x2);
      return ({8{c[0]}} & b) ^ ({8{c[1]}} & x1) ^ ({8{c[2]}} & x2) ^ ({8{c[3]}} & x3);
   endfunction

endpackage

// File: rtl/aes_mcol_seq_col.sv
// Single-column forward/inverse MixColumns, purely combinational.
// Latency: 0 cycles; worst case is three xtime levels plus a 4-input XOR.
// Backpressure: none; the caller owns all handshaking.
module aes_mcol_col
   import aes_const::*;
(
   input  logic [7:0] b0,
   input  logic [7:0] b1,
   input  logic [7:0] b2,
   input  logic [7:0] b3,
   input  logic       inv,
   output logic [7:0] m0,
   output logic [7:0] m1,
   output logic [7:0] m2,
   output logic [7:0] m3
);

   logic [7:0] b [4];
   logic [7:0] m [4];

   assign b[0] = b0;
   assign b[1] = b1;
   assign b[2] = b2;
   assign b[3] = b3;

   // Output row r = XOR over j of b[j] * coefficient at offset (j - r) mod 4
   always_comb begin
      m = '{default: 8'h00};
      for (int r = 0; r < 4; r++) begin
         for (int j = 0; j < 4; j++) begin
            m[r] = m[r] ^ gf_mul_c(b[j], mcol_coef(inv, 2'(j - r)));
         end
      end
   end

   assign m0 = m[0];
   assign m1 = m[1];
   assign m2 = m[2];
   assign m3 = m[3];

endmodule

// File: rtl/aes_mcol_seq.sv
// Iterative MixColumns over a full AES state, COLS columns per cycle.
// Latency: Nb/COLS cycles from accept to out_valid; DONE->BUSY reload costs no cycle.
// Backpressure: result held in DONE until out_ready; in_ready low while busy or stalled.
module aes_mcol_seq
   import aes_const::*;
#(
   parameter int Nb   = NB,
   parameter int COLS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                inv,
   input  logic [32*Nb-1:0]    State_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*Nb-1:0]    State_out
);

   localparam int CNT_W = (Nb > 1) ? $clog2(Nb) : 1;

   if (!(COLS == 1 || COLS == 2 || COLS == 4) || (Nb % COLS) != 0) begin : g_bad_cfg
      $error("aes_mcol_seq: COLS must be 1, 2 or 4 and divide Nb");
   end

   mcol_fsm_t              state_q, state_d;
   logic [32*Nb-1:0]       work_q;
   logic                   mode_q;
   logic [CNT_W-1:0]       col_cnt;
   logic                   last_col;
   logic                   accept;
   logic [CNT_W-1:0]       col_idx [COLS];
   logic [31:0]            col_mix [COLS];

   assign last_col  = (int'(col_cnt) + COLS == Nb);
   assign accept    = in_valid & in_ready;
   assign State_out = work_q;

   for (genvar g = 0; g < COLS; g++) begin : g_col
      logic [31:0] col_in;
      logic [7:0]  m0, m1, m2, m3;

      assign col_idx[g] = col_cnt + CNT_W'(g);
      assign col_in     = work_q[32*int'(col_idx[g]) +: 32];

      aes_mcol_col u_col (
         .b0  (col_in[7:0]),
         .b1  (col_in[15:8]),
         .b2  (col_in[23:16]),
         .b3  (col_in[31:24]),
         .inv (mode_q),
         .m0  (m0),
         .m1  (m1),
         .m2  (m2),
         .m3  (m3)
      );

      assign col_mix[g] = {m3, m2, m1, m0};
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next state and handshake decode; DONE may hand off and reload in one cycle
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = BUSY;
         end
         BUSY: begin
            if (last_col) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               in_ready = 1'b1;
               state_d  = in_valid ? BUSY : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Working register: load on accept, then mix COLS columns in place per busy cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         work_q  <= '0;
         mode_q  <= 1'b0;
         col_cnt <= '0;
      end else if (accept) begin
         work_q  <= State_in;
         mode_q  <= inv;
         col_cnt <= '0;
      end else if (state_q == BUSY) begin
         for (int g = 0; g < COLS; g++) begin
            work_q[32*int'(col_idx[g]) +: 32] <= col_mix[g];
         end
         col_cnt <= last_col ? '0 : col_cnt + CNT_W'(COLS);
      end
   end

endmodule

// File: tb/tb_aes_mcol_seq.sv
// Self-checking bench for aes_mcol_seq at COLS = 1, 2, 4 (Nb = 4).
// Latency: checked per transaction against 4/COLS cycles.
// Backpressure: exercised via held out_ready and same-cycle reload.
module tb_aes_mcol_seq;

   localparam int NI = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [NI];
   logic         in_ready  [NI];
   logic         inv       [NI];
   logic [127:0] st_in     [NI];
   logic         out_valid [NI];
   logic         out_ready [NI];
   logic [127:0] st_out    [NI];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      aes_mcol_seq #(.Nb(4), .COLS(1 << k)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .inv       (inv[k]),
         .State_in  (st_in[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .State_out (st_out[k])
      );
   end

   // Matrices written row by row; entry (r,c) at byte 4*r+c from the MSB end
   localparam logic [127:0] FWD_M = {8'h02, 8'h03, 8'h01, 8'h01,
                                     8'h01, 8'h02, 8'h03, 8'h01,
                                     8'h01, 8'h01, 8'h02, 8'h03,
                                     8'h03, 8'h01, 8'h01, 8'h02};
   localparam logic [127:0] INV_M = {8'h0e, 8'h0b, 8'h0d, 8'h09,
                                     8'h09, 8'h0e, 8'h0b, 8'h0d,
                                     8'h0d, 8'h09, 8'h0e, 8'h0b,
                                     8'h0b, 8'h0d, 8'h09, 8'h0e};

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic iv);
      logic [127:0] o, mtx;
      logic [7:0]   acc;
      mtx = iv ? INV_M : FWD_M;
      o = '0;
      for (int col = 0; col < 4; col++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int c = 0; c < 4; c++)
               acc = acc ^ gmul(mtx[127 - 8*(4*r + c) -: 8], s[8*(4*col + c) +: 8]);
            o[8*(4*col + r) +: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] rep(input logic [31:0] col);
      return {col, col, col, col};
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Count edges from accept until out_valid, garbling ignored inputs meanwhile
   task automatic wait_out(input int k, input int exp_lat, output logic [127:0] res);
      int lat;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!out_valid[k]) begin
            in_valid[k] = 1'($urandom);
            st_in[k]    = {$urandom, $urandom, $urandom, $urandom};
            inv[k]      = 1'($urandom);
         end else begin
            in_valid[k] = 1'b0;
         end
      end while (!out_valid[k] && lat < 50);
      in_valid[k] = 1'b0;
      chk("latency", 128'(lat), 128'(exp_lat));
      res = st_out[k];
   endtask

   task automatic send(input int k, input logic [127:0] s, input logic iv,
                       input int exp_lat, output logic [127:0] res);
      int guard;
      @(negedge clk);
      in_valid[k] = 1'b1; st_in[k] = s; inv[k] = iv;
      guard = 0;
      while (!in_ready[k] && guard < 50) begin
         @(negedge clk); guard++;
      end
      if (!in_ready[k]) chk("in_ready_timeout", 128'(in_ready[k]), 128'(1));
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      inv[k]      = ~iv;
      wait_out(k, exp_lat, res);
   endtask

   task automatic drain(input int k);
      @(negedge clk);
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
      chk("drained", 128'(out_valid[k]), 128'(0));
   endtask

   logic [127:0] r, r2, a, b;

   initial begin
      for (int k = 0; k < NI; k++) begin
         in_valid[k] = 1'b0; inv[k] = 1'b0; st_in[k] = '0; out_ready[k] = 1'b0;
      end
      rst = 1'b1;
      #3 rst = 1'b0;
      #4;
      for (int k = 0; k < NI; k++) begin
         chk("rst_out_valid", 128'(out_valid[k]), 128'(0));
         chk("rst_state_out", st_out[k], '0);
         chk("rst_in_ready", 128'(in_ready[k]), 128'(1));
      end
      @(negedge clk); rst = 1'b1;

      // Known forward vector in every column
      send(0, rep(32'h455313db), 1'b0, 4, r);
      chk("fwd_vec", r, rep(32'hbca14d8e));
      drain(0);

      // Known inverse vectors
      a = {32'hf8bd7e4d, 32'hbca14d8e, 32'hf8bd7e4d, 32'hbca14d8e};
      send(0, a, 1'b1, 4, r);
      chk("inv_vec", r, {32'h4c31262d, 32'h455313db, 32'h4c31262d, 32'h455313db});
      drain(0);

      // Identity columns in both modes
      a = {32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6, 32'h01010101};
      send(0, a, 1'b0, 4, r);
      chk("ident_fwd", r, a);
      drain(0);
      send(0, a, 1'b1, 4, r);
      chk("ident_inv", r, a);
      drain(0);

      // Parameter sweep on d4 d4 d4 d5
      for (int k = 0; k < NI; k++) begin
         send(k, rep(32'hd5d4d4d4), 1'b0, 4 >> k, r);
         chk("sweep_vec", r, rep(32'hd6d7d5d5));
         drain(k);
      end

      // Backpressure: hold result, then hand off and reload in one cycle
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      send(0, a, 1'b0, 4, r);
      chk("bp_first", r, mix_ref(a, 1'b0));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_stable", st_out[0], r);
         chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
         chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
      end
      @(negedge clk);
      out_ready[0] = 1'b1; in_valid[0] = 1'b1; st_in[0] = b; inv[0] = 1'b1;
      #1 chk("bp_reload_ready", 128'(in_ready[0]), 128'(1));
      @(posedge clk); #1;
      out_ready[0] = 1'b0; in_valid[0] = 1'b0;
      chk("bp_after_handoff", 128'(out_valid[0]), 128'(0));
      wait_out(0, 4, r2);
      chk("bp_second", r2, mix_ref(b, 1'b1));
      drain(0);

      // Reset in the middle of a block
      a = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      in_valid[0] = 1'b1; st_in[0] = a; inv[0] = 1'b0;
      @(posedge clk); #1 in_valid[0] = 1'b0;
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
      chk("mid_rst_state_out", st_out[0], '0);
      chk("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
      @(negedge clk); rst = 1'b1;
      send(0, a, 1'b0, 4, r);
      chk("post_rst_vec", r, mix_ref(a, 1'b0));
      drain(0);

      // Random round trips across all configurations
      for (int i = 0; i < 1000; i++) begin
         int k;
         k = i % NI;
         a = {$urandom, $urandom, $urandom, $urandom};
         send(k, a, 1'b0, 4 >> k, r);
         chk("rand_fwd", r, mix_ref(a, 1'b0));
         drain(k);
         send(k, r, 1'b1, 4 >> k, r2);
         chk("rand_roundtrip", r2, a);
         drain(k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
